// File: rtl/stall_delay_3.sv
// stall_delay_3: a three-stage elastic delay line. Each stage is a valid bit
// plus a data register; words march S1 -> S2 -> S3 in strict FIFO order.
// When the consumer stalls, empty stages still let the words behind them
// move forward, so the block can hold up to three words.
// The output is taken straight from the S3 registers. in_ready__ is a
// combinational function of out_ready_i, so a stall propagates back to
// the producer in the same cycle.
module stall_delay_3 #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             in_ready__,
    output logic             out_valid__,
    output logic [WIDTH-1:0] output__,
    input  logic             out_ready_i,
    output logic [1:0]       occupancy__
);

    logic             s1_valid;
    logic             s2_valid;
    logic             s3_valid;
    logic [WIDTH-1:0] s1_data;
    logic [WIDTH-1:0] s2_data;
    logic [WIDTH-1:0] s3_data;

    logic s1_advance;
    logic s2_advance;
    logic s3_advance;

    // Ready chain: a stage may load when it is empty or when its word leaves
    // at this edge. The chain is evaluated from the output back to the input.
    always_comb begin
        s3_advance = !s3_valid || out_ready_i;
        s2_advance = !s2_valid || s3_advance;
        s1_advance = !s1_valid || s2_advance;
    end

    // Valid bits: reset wins. Otherwise each advancing stage takes the valid
    // bit from the stage behind it, so a bubble moving forward clears it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s3_valid <= 1'b0;
        end else begin
            if (s3_advance) begin
                s3_valid <= s2_valid;
            end
            if (s2_advance) begin
                s2_valid <= s1_valid;
            end
            if (s1_advance) begin
                s1_valid <= in_valid_i;
            end
        end
    end

    // Data registers: no reset, because the contents are meaningless while
    // the matching valid bit is clear. They shift in step with the valid bits.
    always_ff @(posedge clk_i) begin
        if (s3_advance) begin
            s3_data <= s2_data;
        end
        if (s2_advance) begin
            s2_data <= s1_data;
        end
        if (s1_advance) begin
            s1_data <= in_data_i;
        end
    end

    // Outputs: the producer handshake, the S3 registers, and a count of the
    // valid stages taken directly from the valid bits.
    always_comb begin
        in_ready__  = s1_advance;
        out_valid__ = s3_valid;
        output__    = s3_data;
        occupancy__ = {1'b0, s1_valid} + {1'b0, s2_valid} + {1'b0, s3_valid};
    end

endmodule

// File: tb/tb_stall_delay_3.sv
// tb_stall_delay_3: directed vectors with hand-computed expectations,
// followed by a randomized run checked against a FIFO scoreboard.
module tb_stall_delay_3;

    localparam int WIDTH = 8;

    logic             clk_i;
    logic             rst_i;
    logic             in_valid_i;
    logic [WIDTH-1:0] in_data_i;
    logic             in_ready__;
    logic             out_valid__;
    logic [WIDTH-1:0] output__;
    logic             out_ready_i;
    logic [1:0]       occupancy__;

    int tests_run;
    int tests_failed;

    stall_delay_3 #(.WIDTH(WIDTH)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_valid_i  (in_valid_i),
        .in_data_i   (in_data_i),
        .in_ready__  (in_ready__),
        .out_valid__ (out_valid__),
        .output__    (output__),
        .out_ready_i (out_ready_i),
        .occupancy__ (occupancy__)
    );

    // 10-unit clock period.
    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Drive the input side and the consumer's ready, then let logic settle.
    task automatic applyStimulus(input logic valid, input logic [WIDTH-1:0] data,
                                 input logic ready);
        in_valid_i  = valid;
        in_data_i   = data;
        out_ready_i = ready;
        #1;
    endtask

    // Advance one rising edge and sample shortly after it.
    task automatic tickClock();
        @(posedge clk_i);
        #1;
    endtask

    logic [WIDTH-1:0] model_q[$];
    int               model_count;
    logic             push;
    logic             pop;
    logic             exp_ready;
    logic [WIDTH-1:0] rand_data;
    int               drain_budget;

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_i        = 1'b1;
        applyStimulus(1'b0, 8'h00, 1'b0);

        // Reset for two edges.
        tickClock();
        tickClock();
        rst_i = 1'b0;
        #1;
        checkOutput("reset_out_valid", out_valid__, 0);
        checkOutput("reset_occupancy", occupancy__, 0);
        checkOutput("reset_in_ready", in_ready__, 1);

        // Stream: three words back to back, three-cycle latency.
        applyStimulus(1'b1, 8'h01, 1'b1);
        tickClock();
        applyStimulus(1'b1, 8'h02, 1'b1);
        tickClock();
        checkOutput("stream_not_yet_valid", out_valid__, 0);
        applyStimulus(1'b1, 8'h03, 1'b1);
        tickClock();
        checkOutput("stream_valid_1", out_valid__, 1);
        checkOutput("stream_data_1", output__, 8'h01);
        checkOutput("stream_occ_full", occupancy__, 3);
        applyStimulus(1'b0, 8'hEE, 1'b1);
        tickClock();
        checkOutput("stream_data_2", output__, 8'h02);
        tickClock();
        checkOutput("stream_valid_3", out_valid__, 1);
        checkOutput("stream_data_3", output__, 8'h03);
        tickClock();
        checkOutput("stream_drained_valid", out_valid__, 0);
        checkOutput("stream_drained_occ", occupancy__, 0);

        // Backpressure fill: only three words fit.
        applyStimulus(1'b1, 8'h10, 1'b0);
        tickClock();
        applyStimulus(1'b1, 8'h11, 1'b0);
        tickClock();
        applyStimulus(1'b1, 8'h12, 1'b0);
        tickClock();
        checkOutput("fill_occ", occupancy__, 3);
        checkOutput("fill_data_head", output__, 8'h10);
        applyStimulus(1'b1, 8'h13, 1'b0);
        checkOutput("fill_in_ready_low", in_ready__, 0);
        tickClock();
        checkOutput("fill_occ_hold", occupancy__, 3);
        checkOutput("fill_valid_hold", out_valid__, 1);
        checkOutput("fill_data_hold", output__, 8'h10);

        // Drain with a simultaneous push of 0x13.
        applyStimulus(1'b1, 8'h13, 1'b1);
        checkOutput("drain_in_ready", in_ready__, 1);
        tickClock();
        checkOutput("drain_occ_pushpop", occupancy__, 3);
        checkOutput("drain_data_11", output__, 8'h11);
        applyStimulus(1'b0, 8'hEE, 1'b1);
        tickClock();
        checkOutput("drain_data_12", output__, 8'h12);
        checkOutput("drain_occ_2", occupancy__, 2);
        tickClock();
        checkOutput("drain_data_13", output__, 8'h13);
        checkOutput("drain_occ_1", occupancy__, 1);
        tickClock();
        checkOutput("drain_empty_valid", out_valid__, 0);
        checkOutput("drain_empty_occ", occupancy__, 0);

        // Bubble collapse under a stall.
        applyStimulus(1'b1, 8'h20, 1'b0);
        tickClock();
        applyStimulus(1'b0, 8'hEE, 1'b0);
        tickClock();
        tickClock();
        checkOutput("bubble_head_valid", out_valid__, 1);
        checkOutput("bubble_head_data", output__, 8'h20);
        applyStimulus(1'b1, 8'h21, 1'b0);
        tickClock();
        checkOutput("bubble_occ_2", occupancy__, 2);
        applyStimulus(1'b0, 8'hEE, 1'b0);
        tickClock();
        checkOutput("bubble_occ_still_2", occupancy__, 2);
        checkOutput("bubble_data_held", output__, 8'h20);
        applyStimulus(1'b0, 8'hEE, 1'b1);
        tickClock();
        checkOutput("bubble_exit_21_valid", out_valid__, 1);
        checkOutput("bubble_exit_21", output__, 8'h21);
        tickClock();
        checkOutput("bubble_empty", out_valid__, 0);

        // Reset mid-operation discards all words, even with a push pending.
        applyStimulus(1'b1, 8'h30, 1'b0);
        tickClock();
        applyStimulus(1'b1, 8'h31, 1'b0);
        tickClock();
        applyStimulus(1'b1, 8'h32, 1'b0);
        tickClock();
        checkOutput("midrst_occ_full", occupancy__, 3);
        rst_i = 1'b1;
        applyStimulus(1'b1, 8'h33, 1'b1);
        tickClock();
        rst_i = 1'b0;
        applyStimulus(1'b0, 8'hEE, 1'b1);
        checkOutput("midrst_out_valid", out_valid__, 0);
        checkOutput("midrst_occ", occupancy__, 0);
        checkOutput("midrst_in_ready", in_ready__, 1);
        for (int i = 0; i < 4; i++) begin
            tickClock();
            checkOutput("midrst_no_ghost", out_valid__, 0);
        end

        // Random traffic against a FIFO scoreboard.
        model_count = 0;
        for (int cyc = 0; cyc < 1000; cyc++) begin
            rand_data = WIDTH'($urandom_range(0, 255));
            applyStimulus(1'($urandom_range(0, 1)), rand_data,
                          1'($urandom_range(0, 3) != 0));
            exp_ready = (model_count < 3) || out_ready_i;
            checkOutput("rand_in_ready", in_ready__, exp_ready);
            push = in_valid_i && in_ready__;
            pop  = out_valid__ && out_ready_i;
            if (out_valid__ && model_count == 0) begin
                checkOutput("rand_valid_when_empty", out_valid__, 0);
            end
            if (pop) begin
                if (model_q.size() == 0) begin
                    checkOutput("rand_pop_underflow", 1, 0);
                end else begin
                    checkOutput("rand_out_data", output__, model_q[0]);
                    void'(model_q.pop_front());
                end
            end
            if (push) begin
                model_q.push_back(in_data_i);
            end
            model_count = model_q.size();
            tickClock();
            checkOutput("rand_occupancy", occupancy__, model_count);
        end

        // Drain whatever is left, bounded by a cycle budget.
        applyStimulus(1'b0, 8'hEE, 1'b1);
        drain_budget = 10;
        while (model_q.size() != 0 && drain_budget > 0) begin
            if (out_valid__) begin
                checkOutput("final_drain_data", output__, model_q[0]);
                void'(model_q.pop_front());
            end
            tickClock();
            drain_budget--;
        end
        checkOutput("final_drain_left", model_q.size(), 0);
        checkOutput("final_occupancy", occupancy__, 0);
        checkOutput("final_out_valid", out_valid__, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
